// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one external signed WxW multiplier
// between two valid/ready requesters, with a single tagged result channel.
module mult_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    output logic             req1_ready,
    output logic [W-1:0]     mul_in0,
    output logic [W-1:0]     mul_in1,
    input  logic [2*W-1:0]   mul_out,
    output logic             res_valid,
    output logic [2*W-1:0]   res_data,
    output logic             res_id,
    input  logic             res_ready,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       mul_in0_q, mul_in1_q;
    logic               owner_q;
    logic               last_grant_q;
    logic               res_valid_q;
    logic [2*W-1:0]     res_data_q;
    logic               res_id_q;
    logic [CNT_W-1:0]   done_cnt_q;

    logic               grant_vld;
    logic               grant_id;
    logic               res_hs;

    // Arbitration: a tie goes to the requester that was not granted last.
    // Nothing is granted while reset is high so no handshake can occur then.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant_q;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign res_hs = (state_q == DONE) && res_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: accept -> one multiply cycle -> hold until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = CALC;
            CALC:    state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: at most one ready, only toward the granted requester.
    always_comb begin
        req0_ready = grant_vld && !grant_id;
        req1_ready = grant_vld &&  grant_id;
    end

    // Datapath: operand latch on accept, product capture in CALC, counter on handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_in0_q    <= '0;
            mul_in1_q    <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
            done_cnt_q   <= '0;
        end else begin
            if (grant_vld) begin
                mul_in0_q    <= grant_id ? req1_a : req0_a;
                mul_in1_q    <= grant_id ? req1_b : req0_b;
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == CALC) begin
                res_data_q  <= mul_out;
                res_id_q    <= owner_q;
                res_valid_q <= 1'b1;
            end
            if (res_hs) begin
                res_valid_q <= 1'b0;
                done_cnt_q  <= done_cnt_q + 1'b1;
            end
        end
    end

    assign mul_in0    = mul_in0_q;
    assign mul_in1    = mul_in1_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
    assign done_count = done_cnt_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter; includes a behavioural signed 4x4 multiplier.
module tb_mult_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_ready, req1_ready;
    logic [3:0] mul_in0, mul_in1;
    logic [7:0] mul_out;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_id;
    logic       res_ready;
    logic [7:0] done_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // External multiplier: sign-extend to 8 bits, product mod 256 is exact.
    assign mul_out = {{4{mul_in0[3]}}, mul_in0} * {{4{mul_in1[3]}}, mul_in1};

    mult_arbiter #(.W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_out(mul_out),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .done_count(done_count)
    );

    // Every task starts and ends 1ns after a rising edge.
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Stimulus only: run one operation on requester id, return what came back.
    task automatic do_op(input bit id, input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] data, output logic rid, output bit ok);
        int n;
        ok = 1'b0; data = '0; rid = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        res_ready = 1'b0;
        n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 8) begin
            @(posedge clk); #2; n++;
        end
        if (n >= 8) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 8) begin @(posedge clk); #1; n++; end
        if (!res_valid) return;
        data = res_data; rid = res_id; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'd1; req0_b = 4'd1; req1_a = 4'd1; req1_b = 4'd1;
        res_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            fails++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        tests++;
        if ({mul_in0, mul_in1, res_valid, res_data, res_id, done_count} !== '0) begin
            fails++;
            $display("FAIL reset_values: got in0=%h in1=%h v=%b d=%h id=%b cnt=%h expected all 0",
                     mul_in0, mul_in1, res_valid, res_data, res_id, done_count);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #9; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'hE; res_ready = 1'b0;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        tests++;
        if ({mul_in0, mul_in1, res_valid} !== {4'd3, 4'hE, 1'b0}) begin
            fails++; $display("FAIL single_mulin: got %h %h v=%b expected 3 e v=0", mul_in0, mul_in1, res_valid);
        end
        tests++;
        if (req0_ready !== 1'b0) begin
            fails++; $display("FAIL single_ready_calc: got %b expected 0", req0_ready);
        end
        @(posedge clk); #1;
        tests++;
        if ({res_valid, res_data, res_id} !== {1'b1, 8'hFA, 1'b0}) begin
            fails++; $display("FAIL single_result: got v=%b d=%h id=%b expected v=1 d=fa id=0",
                              res_valid, res_data, res_id);
        end
        req0_valid = 1'b0; res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        tests++;
        if ({res_valid, done_count} !== {1'b0, 8'd1}) begin
            fails++; $display("FAIL single_done: got v=%b cnt=%0d expected v=0 cnt=1", res_valid, done_count);
        end
    endtask

    task automatic test_extremes();
        logic [3:0] ea [4] = '{4'h8, 4'h8, 4'h7, 4'h0};
        logic [3:0] eb [4] = '{4'h8, 4'h7, 4'h7, 4'hB};
        logic [7:0] exp_d [4] = '{8'h40, 8'hC8, 8'h31, 8'h00};
        logic [7:0] d;
        logic rid;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            do_op(i[0], ea[i], eb[i], d, rid, ok);
            tests++;
            if (!ok || d !== exp_d[i] || rid !== i[0]) begin
                fails++; $display("FAIL extremes_%0d: got ok=%b d=%h id=%b expected d=%h id=%b",
                                  i, ok, d, rid, exp_d[i], i[0]);
            end
        end
    endtask

    task automatic test_tie_rr();
        int acc_n = 0, res_n = 0;
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'hF; req1_b = 4'd4;
        res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready && req1_ready) begin
                tests++; fails++; $display("FAIL tie_both_ready: cycle %0d", c);
            end
            if (req0_ready || req1_ready) begin
                tests++;
                if (req1_ready !== acc_n[0] || c != 3 * acc_n) begin
                    fails++; $display("FAIL tie_grant_%0d: got id=%b cycle=%0d expected id=%b cycle=%0d",
                                      acc_n, req1_ready, c, acc_n[0], 3 * acc_n);
                end
                acc_n++;
            end
            if (res_valid) begin
                tests++;
                if (res_id !== res_n[0] || res_data !== (res_n[0] ? 8'hFC : 8'h06) || c != 3 * res_n + 2) begin
                    fails++; $display("FAIL tie_result_%0d: got id=%b d=%h cycle=%0d expected id=%b d=%h cycle=%0d",
                                      res_n, res_id, res_data, c, res_n[0],
                                      (res_n[0] ? 8'hFC : 8'h06), 3 * res_n + 2);
                end
                res_n++;
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        tests++;
        if (acc_n != 4 || res_n != 4 || done_count !== 8'd4) begin
            fails++; $display("FAIL tie_counts: got acc=%0d res=%0d cnt=%0d expected 4 4 4", acc_n, res_n, done_count);
        end
    endtask

    task automatic test_backpressure();
        bit bad = 1'b0;
        apply_reset();
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'hF; req1_b = 4'd4;
        res_ready = 1'b0;
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++; $display("FAIL bp_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if ({res_valid, res_data, res_id, req0_ready, req1_ready} !== {1'b1, 8'h06, 1'b0, 2'b00}) begin
                bad = 1'b1;
                $display("FAIL bp_hold_%0d: got v=%b d=%h id=%b rdy=%b%b expected v=1 d=06 id=0 rdy=00",
                         i, res_valid, res_data, res_id, req0_ready, req1_ready);
            end
            @(posedge clk); #1;
        end
        tests++;
        if (bad) fails++;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        #1;
        tests++;
        if ({res_valid, done_count, req0_ready, req1_ready} !== {1'b0, 8'd1, 2'b01}) begin
            fails++; $display("FAIL bp_after: got v=%b cnt=%0d rdy=%b%b expected v=0 cnt=1 rdy=01",
                              res_valid, done_count, req0_ready, req1_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset_in_done();
        logic [7:0] d;
        logic rid;
        bit ok;
        apply_reset();
        do_op(1'b1, 4'd1, 4'd5, d, rid, ok);
        req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++;
        if ({res_valid, res_data, done_count} !== {1'b1, 8'h0E, 8'd1}) begin
            fails++; $display("FAIL rid_pre: got v=%b d=%h cnt=%0d expected v=1 d=0e cnt=1",
                              res_valid, res_data, done_count);
        end
        reset = 1'b1; res_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; res_ready = 1'b0;
        tests++;
        if ({res_valid, res_data, done_count, mul_in0} !== '0) begin
            fails++; $display("FAIL rid_cleared: got v=%b d=%h cnt=%0d in0=%h expected all 0",
                              res_valid, res_data, done_count, mul_in0);
        end
        #1;
        tests++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            fails++; $display("FAIL rid_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        apply_reset();
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic rid;
        bit ok;
        int errs = 0;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            do_op(i[0], 4'd2, 4'hD, d, rid, ok);
            if (!ok || d !== 8'hFA || rid !== i[0]) errs++;
            if (i == 254) begin
                tests++;
                if (done_count !== 8'd255) begin
                    fails++; $display("FAIL wrap_255: got %0d expected 255", done_count);
                end
            end
        end
        tests++;
        if (errs != 0) begin
            fails++; $display("FAIL wrap_results: got %0d bad ops expected 0", errs);
        end
        tests++;
        if (done_count !== 8'd0) begin
            fails++; $display("FAIL wrap_zero: got %0d expected 0", done_count);
        end
    endtask

    initial begin
        reset = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_extremes();
        test_tie_rr();
        test_backpressure();
        test_reset_in_done();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one external signed 4x4 `mult` instance between two requesters. Each requester offers an operand pair over a valid/ready handshake. The block registers the granted pair onto the multiplier inputs, captures the product one cycle later, and presents it on a single tagged result channel with valid/ready backpressure. It sits between the input-capture logic (switches/buttons or a PS-side register interface) and the output display logic on the ZedBoard.

## Interface
- `W`, 4: operand width; product width is 2·W. Must match the attached multiplier.
- `CNT_W`, 8: width of the completed-operation counter.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: requester 0 offers an operand pair.
- `req0_a`, `req0_b` in W each: requester 0 signed operands.
- `req0_ready` out 1: requester 0 pair is accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as requester 0, for requester 1.
- `mul_in0`, `mul_in1` out W each: registered operands driven to the shared multiplier.
- `mul_out` in 2W: signed product returned combinationally by the multiplier.
- `res_valid` out 1: result held and valid.
- `res_data` out 2W: signed product.
- `res_id` out 1: index of the requester that owns `res_data`.
- `res_ready` in 1: downstream accepts the result.
- `done_count` out CNT_W: number of completed result handshakes, wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE transitions:
  - No requester valid: stay in IDLE.
  - At least one requester valid: grant one requester, assert its `reqN_ready` combinationally in the same cycle, then on the clock edge:
    - latch `a` into `mul_in0` and `b` into `mul_in1`;
    - latch the grant index into `owner`;
    - set `last_grant` to the grant index;
    - go to CALC.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester whose index ≠ `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- Ready rules:
  - At most one `reqN_ready` is high in any cycle.
  - Both ready outputs are 0 outside IDLE.
  - A ready output is 0 when its own valid is 0.
- CALC: on the clock edge, capture `mul_out` into `res_data` and `owner` into `res_id`, set `res_valid` to 1, then go to DONE. This is unconditional and takes exactly one cycle.
- DONE: hold `res_valid`, `res_data` and `res_id` stable until `res_ready` is 1. On that edge:
  - clear `res_valid`;
  - increment `done_count`;
  - go to IDLE.
- `mul_in0`/`mul_in1` keep their last values outside IDLE acceptances; they are not cleared after use.
- Arithmetic: `mul_out` is the full signed 2W-bit product and is never truncated or saturated. With W=4 the range is −56 … +64 (−8·7 … −8·−8).
- Reset values: `mul_in0`=0, `mul_in1`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `done_count`=0, `last_grant`=1, state IDLE. Both ready outputs are 0 while `reset` is high.
- Reset mid-operation (CALC or DONE): the pending result is discarded and `done_count` clears. No handshake occurs on the reset cycle.
- Requester valids that drop while the requester is not granted are legal; the block holds no state for ungranted requests.

## Timing
- Acceptance edge T (`reqN_valid` and `reqN_ready` both high): `mul_in*` updated after T, `res_valid` high after T+1. Latency is 2 cycles.
- Minimum spacing between acceptances is 3 cycles: accept, CALC, DONE with `res_ready` held high, then IDLE accepts again.
- `res_ready` is ignored outside DONE.
- `done_count` wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- Single request: `req0` a=3, b=−2 held valid. Required: `req0_ready`=1 in the first cycle; `res_valid`=1 two cycles later with `res_data`=−6 (8'hFA) and `res_id`=0; `done_count`=1 after handshake.
- Extremes: pairs (−8,−8), (−8,7), (7,7), (0,−5). Required: `res_data` = 64, −56, 49, 0 in order.
- Tie round-robin: both requesters valid continuously, `res_ready`=1. Required: grants alternate 0,1,0,1 from reset, with `res_id` matching the grant, and one result every 3 cycles.
- Backpressure: `res_ready`=0 for 5 cycles in DONE while both valids are high. Required: `res_valid`, `res_data` and `res_id` held stable; both ready outputs 0; next grant occurs only after the handshake.
- Reset in DONE: assert `reset` for one cycle while `res_valid`=1. Required: next cycle `res_valid`=0, `done_count`=0, `last_grant`=1, and requester 0 wins the next tie.
- Counter wrap: 256 completed operations with CNT_W=8. Required: `done_count` returns to 0.
